// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: state encoding,
// default integrity sentinel and a helper for the partial last byte.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SENT = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } ccff_state_t;

  localparam logic [7:0] DEFAULT_SENTINEL = 8'hA5;

  // Number of useful bits in the final byte of a chain of the given length.
  function automatic int last_byte_bits(input int chain_len);
    return ((chain_len % 8) == 0) ? 8 : (chain_len % 8);
  endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// Byte stream handshake feeding the configuration loader.
interface ccff_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ccff_loader.sv
// Serialises a configuration bitstream MSB-first into the fabric chain,
// gating prog_clk via shift_en and checking a sentinel that runs the full chain.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int         CHAIN_LEN = 64,
  parameter logic [7:0] SENTINEL  = DEFAULT_SENTINEL
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  ccff_loader_if.slave      in_bus,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              done,
  output logic              chain_ok
);

  localparam int N      = CHAIN_LEN + 8;
  localparam int W      = (CHAIN_LEN + 7) / 8;
  localparam int LAST   = last_byte_bits(CHAIN_LEN);
  localparam int BIT_W  = $clog2(CHAIN_LEN + 9);
  localparam int BYTE_W = $clog2(W + 1);

  ccff_state_t       state_q, state_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [3:0]        buf_cnt_q, buf_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]        tail_sr_q, tail_sr_d;
  logic              shift_en_q, shift_en_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;
  logic              ready_c;
  logic              accept;

  // The shift register doubles as the skid buffer: a new byte may land on the
  // same edge the last buffered bit leaves, keeping shift_en continuous.
  assign ready_c = ((state_q == SENT) || (state_q == LOAD)) &&
                   (byte_cnt_q < BYTE_W'(W)) &&
                   ((buf_cnt_q == 4'd0) || ((buf_cnt_q == 4'd1) && shift_en_q));
  assign accept  = in_bus.in_valid && ready_c;

  assign in_bus.in_ready = ready_c;
  assign ccff_head       = shreg_q[7];
  assign shift_en        = shift_en_q;
  assign done            = done_q;
  assign chain_ok        = ok_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    buf_cnt_d  = buf_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tail_sr_d  = tail_sr_q;
    ok_d       = ok_q;
    done_d     = 1'b0;
    shift_en_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = SENT;
          shreg_d    = SENTINEL;
          buf_cnt_d  = 4'd8;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          tail_sr_d  = '0;
          ok_d       = 1'b0;
          shift_en_d = 1'b1;
        end
      end
      default: begin
        if (shift_en_q) begin
          if (bit_cnt_q != BIT_W'(N)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (bit_cnt_q >= BIT_W'(CHAIN_LEN)) begin
            tail_sr_d = {tail_sr_q[6:0], ccff_tail};
          end
          if (buf_cnt_q > 4'd1) begin
            shreg_d   = {shreg_q[6:0], 1'b0};
            buf_cnt_d = buf_cnt_q - 4'd1;
          end else begin
            buf_cnt_d = 4'd0;
          end
          if (bit_cnt_q == BIT_W'(7)) begin
            state_d = LOAD;
          end
          if (bit_cnt_q == BIT_W'(N - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            ok_d    = ({tail_sr_q[6:0], ccff_tail} == SENTINEL);
          end
        end
        // The final byte only carries the bits the chain still needs.
        if (accept) begin
          shreg_d    = in_bus.in_data;
          byte_cnt_d = byte_cnt_q + 1'b1;
          buf_cnt_d  = (byte_cnt_q == BYTE_W'(W - 1)) ? 4'(LAST) : 4'd8;
        end
        shift_en_d = (buf_cnt_d != 4'd0) && (state_d != DONE);
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      buf_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tail_sr_q  <= '0;
      shift_en_q <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      buf_cnt_q  <= buf_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tail_sr_q  <= tail_sr_d;
      shift_en_q <= shift_en_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with a 20-flop chain model clocked on
// prog_clk gated by shift_en.
module tb_ccff_loader;
  import ccff_pkg::*;

  localparam int CHAIN_LEN = 20;

  logic        prog_clk = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic        ccff_head;
  logic        shift_en;
  logic        ccff_tail;
  logic        done;
  logic        chain_ok;
  logic        short_mode = 1'b0;
  logic [19:0] chain;

  int          errors = 0;
  int          checks = 0;
  int          shift_cnt = 0;
  int          rises = 0;
  int          since_start = 0;
  logic        prev_se = 1'b0;
  logic [27:0] stream = '0;

  ccff_loader_if bus ();

  ccff_loader #(.CHAIN_LEN(CHAIN_LEN), .SENTINEL(DEFAULT_SENTINEL)) dut (
    .prog_clk (prog_clk),
    .reset    (reset),
    .start    (start),
    .in_bus   (bus),
    .ccff_head(ccff_head),
    .shift_en (shift_en),
    .ccff_tail(ccff_tail),
    .done     (done),
    .chain_ok (chain_ok)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model; short_mode taps one flop early to emulate a broken chain.
  always @(posedge prog_clk) begin
    if (shift_en) chain <= {chain[18:0], ccff_head};
  end
  assign ccff_tail = short_mode ? chain[18] : chain[19];

  // Observer: head bit history, shift count, shift_en rising edges, start latency.
  always @(negedge prog_clk) begin
    if (shift_en) begin
      shift_cnt = shift_cnt + 1;
      stream    = {stream[26:0], ccff_head};
      if (!prev_se) rises = rises + 1;
    end
    prev_se = shift_en;
    if (start) since_start = 0;
    else since_start = since_start + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] getByte(input int i);
    case (i)
      0:       return 8'hF0;
      1:       return 8'h0F;
      default: return 8'hC0;
    endcase
  endfunction

  task automatic waitReady(input string tag);
    int to;
    to = 0;
    while (!bus.in_ready && to < 100) begin
      @(posedge prog_clk); #1;
      to++;
    end
    checkOutput(tag, 32'(to < 100), 32'd1);
  endtask

  // One complete load of 0xF0,0x0F,0xC0; gap>0 inserts stalls before bytes 1 and 2.
  task automatic applyStimulus(input int gap, input bit extra, input bit start_mid,
                               input bit short_i, input bit exp_ok);
    int   to;
    int   shift_base;
    int   rise_base;
    bit   bad_ready;
    bit   gap_se;
    @(posedge prog_clk); #1;
    short_mode = short_i;
    start      = 1'b1;
    shift_base = shift_cnt;
    rise_base  = rises;
    gap_se     = 1'b0;
    @(posedge prog_clk); #1;
    start = 1'b0;
    @(negedge prog_clk); #1;
    checkOutput("start_shift_en", 32'(shift_en), 32'd1);
    checkOutput("start_head", 32'(ccff_head), 32'd1);

    for (int i = 0; i < 3; i++) begin
      if (gap > 0 && i > 0) begin
        bus.in_valid = 1'b0;
        waitReady("gap_ready_wait");
        @(posedge prog_clk); #1;
        for (int g = 0; g < gap; g++) begin
          if (shift_en) gap_se = 1'b1;
          start = start_mid && (i == 1) && (g == 0);
          @(posedge prog_clk); #1;
        end
        start = 1'b0;
      end
      bus.in_data  = getByte(i);
      bus.in_valid = 1'b1;
      waitReady("ready_wait");
      @(posedge prog_clk); #1;
    end

    bus.in_valid = extra;
    bus.in_data  = 8'h55;
    bad_ready    = 1'b0;
    to           = 0;
    while (!done && to < 200) begin
      if (bus.in_ready) bad_ready = 1'b1;
      @(negedge prog_clk); #1;
      to++;
    end
    checkOutput("done_seen", 32'(done), 32'd1);
    if (gap == 0) checkOutput("done_latency", 32'(since_start), 32'd29);
    checkOutput("shift_count", 32'(shift_cnt - shift_base), 32'd28);
    checkOutput("head_stream", 32'(stream), 32'h0A5F00FC);
    checkOutput("shift_en_runs", 32'(rises - rise_base), (gap > 0) ? 32'd3 : 32'd1);
    if (gap > 0) checkOutput("gap_shift_en_low", 32'(gap_se), 32'd0);
    if (!short_i) checkOutput("chain_data", 32'(chain), 32'h000F00FC);
    if (extra) checkOutput("extra_byte_ready", 32'(bad_ready), 32'd0);
    checkOutput("chain_ok", 32'(chain_ok), 32'(exp_ok));
    bus.in_valid = 1'b0;
    @(negedge prog_clk); #1;
    checkOutput("done_pulse", 32'(done), 32'd0);
    repeat (3) @(negedge prog_clk);
    #1;
    checkOutput("chain_ok_hold", 32'(chain_ok), 32'(exp_ok));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_shift_en"}, 32'(shift_en), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_chain_ok"}, 32'(chain_ok), 32'd0);
    checkOutput({tag, "_head"}, 32'(ccff_head), 32'd0);
  endtask

  initial begin
    int to;
    int base;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1;
    checkIdleOutputs("reset");
    reset = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    checkIdleOutputs("idle");

    $display("[TB] continuous load with extra byte offered");
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b1);
    $display("[TB] stalled load, restart from DONE, start pulsed in LOAD");
    applyStimulus(5, 1'b0, 1'b1, 1'b0, 1'b1);
    $display("[TB] short chain model");
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset during LOAD");
    @(posedge prog_clk); #1;
    short_mode   = 1'b0;
    start        = 1'b1;
    base         = shift_cnt;
    bus.in_data  = 8'hF0;
    bus.in_valid = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    to = 0;
    while ((shift_cnt - base) != 20 && to < 100) begin
      @(posedge prog_clk); #1;
      to++;
    end
    checkOutput("reset_point", 32'(shift_cnt - base), 32'd20);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge prog_clk); #1;
    reset = 1'b0;
    checkIdleOutputs("midreset");
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
